xadc_drp_scheduler: RTL and testbench
=====================================

Name: xadc_drp_scheduler

Overview:
- Sequences all accesses to the XADC DRP port.
- Continuously round-robin scans the on-chip sensor status registers (temperature, VCCINT, VCCAUX, VCCBRAM) and caches each result for CPU reads.
- Arbitrates single CPU-requested raw DRP reads/writes (configuration, alarm thresholds) into the scan without collisions.
- Sits between the 8-bit CPU bus decode and the xadc_wiz_0 instance, which is instantiated at top level.

Parameters:
- BaseAddress, 0, first bus address of the 9-register window.
- address_width, 16, CPU bus address width.
- data_width, 8, CPU bus data width; logic uses bits [7:0].
- TimeoutCycles, 255, max cycles waiting for drdy before abort.

Ports:
- clk_i  in  1  system clock; also DRP dclk.
- reset_i  in  1  synchronous, active-high reset.
- address_i  in  address_width  CPU bus address.
- data_i  in  data_width  CPU write data.
- data_o  out  data_width  CPU read data, registered.
- rd_wr_i  in  1  0 = read, 1 = write; each cycle with 1 and a matching address is one write.
- drp_daddr_o  out  7  DRP address.
- drp_den_o  out  1  DRP enable, one-cycle pulse.
- drp_dwe_o  out  1  DRP write enable, only together with den.
- drp_di_o  out  16  DRP write data.
- drp_do_i  in  16  DRP read data.
- drp_drdy_i  in  1  DRP ready.
- drp_busy_i  in  1  XADC busy.

Behaviour:
- Register map (offsets from BaseAddress):
  - +0 TEMP, +1 VCCINT, +2 VCCAUX, +3 VCCBRAM (RO): cached result bits [15:8], i.e. the upper 8 of the 12-bit code.
  - +4 STATUS: bit0 scan_en (RW, reset 1); bit1 man_pending (RO); bit2 timeout (sticky, write 1 clears); other bits read 0.
  - +5 MADDR (RW, 7 bits).
  - +6 MDATA_LO and +7 MDATA_HI (RW): hold write data; after a manual read they are overwritten with drp_do_i.
  - +8 MCMD (WO, reads 0): write 0x01 = manual read, 0x02 = manual write; other values are ignored.
- Bus reads: data_o updates 1 cycle after address_i when rd_wr_i=0. Unmapped addresses return 0. data_o holds its value during writes.
- Bus writes while man_pending=1: writes to MADDR, MDATA_LO, MDATA_HI and MCMD are ignored.
- Reset (any state, including mid-transaction):
  - state=IDLE; den, dwe and daddr drive 0; di drives 0; data_o=0.
  - Cache registers and MADDR/MDATA cleared to 0; scan_en=1; man_pending=0; timeout=0; scan slot=0.
- Scan address table, slot 0..3: 0x00, 0x01, 0x02, 0x06.
- FSM, one transaction in flight at a time:
  - IDLE: if drp_busy_i=0 and (man_pending or scan_en), go to ISSUE. Manual has priority over scan.
  - ISSUE (1 cycle): den=1; daddr = MADDR or table[slot]; dwe=1 and di={MDATA_HI,MDATA_LO} only for a manual write. Latch the owner (manual or scan). Go to WAIT and clear the timeout counter.
  - WAIT: on drdy go to STORE. If the counter reaches TimeoutCycles without drdy: set timeout, clear man_pending if the owner is manual, advance slot if the owner is scan, leave data unchanged, go to IDLE.
  - STORE (1 cycle):
    - Scan owner: cache[slot] <= drp_do_i[15:8]; slot <= slot+1 mod 4.
    - Manual read: MDATA <= drp_do_i.
    - Manual write: MDATA unchanged.
    - In all cases clear man_pending and go to IDLE.
- drdy outside WAIT is ignored.
- Manual request latency: at most one in-flight scan transaction plus 2 cycles to den.
- A STATUS write setting bit2 in the same cycle that a timeout fires: the set wins.
- Clearing scan_en mid-scan completes the current transaction and then stops.

Decomposition:
- Package xadc_pkg holds:
  - state_t enum {idle_e, issue_e, wait_e, store_e};
  - register offset localparams;
  - command codes;
  - the scan DRP address table as a 4-entry constant.
- No sub-module. The FSM, register file and timeout counter live in one module.

Test Plan:
- Reset, DRP model returns 0x9B20 at addr 0x00 → within 10 cycles a read of Base+0 gives 0x9B. drp_daddr_o sequence per den is 0x00, 0x01, 0x02, 0x06, 0x00.
- Hold drp_busy_i=1 for 50 cycles after reset → drp_den_o stays 0. First den occurs 2 cycles after busy drops.
- During an active scan WAIT, write MADDR=0x41 then MCMD=0x01; model returns 0x1234 → the next den has daddr 0x41, dwe=0. Then Base+6 reads 0x34, Base+7 reads 0x12, and STATUS bit1 reads 0.
- Write MADDR=0x42, MDATA=0xABCD, MCMD=0x02 → exactly one cycle with den=1, dwe=1, daddr=0x42, di=0xABCD. Cache registers are unchanged.
- Model withholds drdy → 255 cycles after den, STATUS reads 0x05. The next den goes to the next slot. Writing STATUS=0x05 clears the flag, after which STATUS reads 0x01.
- Assert reset_i for 1 cycle during WAIT → den=0 next cycle, all readback registers are 0, STATUS=0x01, and scanning restarts at slot 0.

Source files
------------

// File: rtl/xadc_pkg.sv
// Shared types and constants for the XADC DRP scheduler: FSM states, CPU register
// offsets, manual command codes and the sensor scan address table.
package xadc_pkg;

  typedef enum logic [1:0] {
    idle_e,
    issue_e,
    wait_e,
    store_e
  } state_t;

  localparam int REG_COUNT = 9;

  localparam logic [3:0] OFF_TEMP     = 4'd0;
  localparam logic [3:0] OFF_VCCINT   = 4'd1;
  localparam logic [3:0] OFF_VCCAUX   = 4'd2;
  localparam logic [3:0] OFF_VCCBRAM  = 4'd3;
  localparam logic [3:0] OFF_STATUS   = 4'd4;
  localparam logic [3:0] OFF_MADDR    = 4'd5;
  localparam logic [3:0] OFF_MDATA_LO = 4'd6;
  localparam logic [3:0] OFF_MDATA_HI = 4'd7;
  localparam logic [3:0] OFF_MCMD     = 4'd8;

  localparam logic [7:0] CMD_READ  = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  // Slot 0..3: temperature, VCCINT, VCCAUX, VCCBRAM status registers.
  localparam logic [3:0][6:0] SCAN_ADDR_TABLE = {7'h06, 7'h02, 7'h01, 7'h00};

endpackage

// File: rtl/xadc_drp_scheduler.sv
// Owns the XADC DRP port: round-robin sensor scan with cached results, plus
// CPU-requested single raw DRP reads/writes slotted between scan transactions.
module xadc_drp_scheduler
  import xadc_pkg::*;
#(
  parameter int BaseAddress   = 0,
  parameter int address_width = 16,
  parameter int data_width    = 8,
  parameter int TimeoutCycles = 255
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [address_width-1:0] address_i,
  input  logic [data_width-1:0]    data_i,
  output logic [data_width-1:0]    data_o,
  input  logic                     rd_wr_i,
  output logic [6:0]               drp_daddr_o,
  output logic                     drp_den_o,
  output logic                     drp_dwe_o,
  output logic [15:0]              drp_di_o,
  input  logic [15:0]              drp_do_i,
  input  logic                     drp_drdy_i,
  input  logic                     drp_busy_i
);

  localparam int CNT_W = $clog2(TimeoutCycles + 1);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TimeoutCycles);
  localparam logic [address_width-1:0] BASE = address_width'(BaseAddress);
  localparam logic [address_width-1:0] WIN  = address_width'(REG_COUNT);

  state_t            state_q, state_d;
  logic              owner_man_q, owner_man_d;
  logic              man_wr_q, man_wr_d;
  logic              man_pending_q, man_pending_d;
  logic              scan_en_q, scan_en_d;
  logic              timeout_q, timeout_d;
  logic [1:0]        slot_q, slot_d;
  logic [7:0]        cache_q [4];
  logic [7:0]        cache_d [4];
  logic [6:0]        maddr_q, maddr_d;
  logic [15:0]       mdata_q, mdata_d;
  logic [15:0]       rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [data_width-1:0] data_o_q, data_o_d;
  logic              den_q, den_d;
  logic              dwe_q, dwe_d;
  logic [6:0]        daddr_q, daddr_d;
  logic [15:0]       di_q, di_d;

  logic [address_width-1:0] offset_full;
  logic [3:0]        offset;
  logic              in_win;
  logic              bus_wr;
  logic              cfg_wr;
  logic [7:0]        wdata;
  logic [7:0]        rd_val;
  logic [CNT_W-1:0]  cnt_inc;

  assign offset_full = address_i - BASE;
  assign offset      = offset_full[3:0];
  assign in_win      = (address_i >= BASE) && (offset_full < WIN);
  assign bus_wr      = rd_wr_i && in_win;
  // The manual request registers are frozen while a request is outstanding.
  assign cfg_wr      = bus_wr && !man_pending_q;
  assign wdata       = data_i[7:0];
  assign cnt_inc     = cnt_q + 1'b1;

  always_comb begin
    rd_val = 8'h00;
    case (offset)
      OFF_TEMP, OFF_VCCINT, OFF_VCCAUX, OFF_VCCBRAM: rd_val = cache_q[offset[1:0]];
      OFF_STATUS:   rd_val = {5'b0, timeout_q, man_pending_q, scan_en_q};
      OFF_MADDR:    rd_val = {1'b0, maddr_q};
      OFF_MDATA_LO: rd_val = mdata_q[7:0];
      OFF_MDATA_HI: rd_val = mdata_q[15:8];
      default:      rd_val = 8'h00;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    owner_man_d   = owner_man_q;
    man_wr_d      = man_wr_q;
    man_pending_d = man_pending_q;
    scan_en_d     = scan_en_q;
    timeout_d     = timeout_q;
    slot_d        = slot_q;
    cache_d       = cache_q;
    maddr_d       = maddr_q;
    mdata_d       = mdata_q;
    rdata_d       = rdata_q;
    cnt_d         = cnt_q;
    data_o_d      = data_o_q;
    den_d         = 1'b0;
    dwe_d         = 1'b0;
    daddr_d       = daddr_q;
    di_d          = di_q;

    if (!rd_wr_i) begin
      data_o_d      = '0;
      data_o_d[7:0] = in_win ? rd_val : 8'h00;
    end

    if (bus_wr && offset == OFF_STATUS) begin
      scan_en_d = wdata[0];
      if (wdata[2]) timeout_d = 1'b0;
    end
    if (cfg_wr) begin
      case (offset)
        OFF_MADDR:    maddr_d = wdata[6:0];
        OFF_MDATA_LO: mdata_d[7:0] = wdata;
        OFF_MDATA_HI: mdata_d[15:8] = wdata;
        OFF_MCMD: begin
          if (wdata == CMD_READ) begin
            man_pending_d = 1'b1;
            man_wr_d      = 1'b0;
          end else if (wdata == CMD_WRITE) begin
            man_pending_d = 1'b1;
            man_wr_d      = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // FSM evaluated after the bus writes so a timeout outranks a same-cycle clear.
    case (state_q)
      idle_e: begin
        if (!drp_busy_i && (man_pending_q || scan_en_q)) state_d = issue_e;
      end
      issue_e: begin
        den_d       = 1'b1;
        owner_man_d = man_pending_q;
        if (man_pending_q) begin
          daddr_d = maddr_q;
          if (man_wr_q) begin
            dwe_d = 1'b1;
            di_d  = mdata_q;
          end
        end else begin
          daddr_d = SCAN_ADDR_TABLE[slot_q];
        end
        cnt_d   = '0;
        state_d = wait_e;
      end
      wait_e: begin
        if (drp_drdy_i) begin
          rdata_d = drp_do_i;
          state_d = store_e;
        end else if (cnt_inc == TO_LIMIT) begin
          timeout_d = 1'b1;
          if (owner_man_q) man_pending_d = 1'b0;
          else             slot_d = slot_q + 2'd1;
          state_d = idle_e;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      store_e: begin
        if (owner_man_q) begin
          if (!man_wr_q) mdata_d = rdata_q;
          man_pending_d = 1'b0;
        end else begin
          cache_d[slot_q] = rdata_q[15:8];
          slot_d          = slot_q + 2'd1;
        end
        state_d = idle_e;
      end
      default: state_d = idle_e;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= idle_e;
      owner_man_q   <= 1'b0;
      man_wr_q      <= 1'b0;
      man_pending_q <= 1'b0;
      scan_en_q     <= 1'b1;
      timeout_q     <= 1'b0;
      slot_q        <= 2'd0;
      for (int i = 0; i < 4; i++) cache_q[i] <= 8'h00;
      maddr_q       <= 7'h00;
      mdata_q       <= 16'h0000;
      rdata_q       <= 16'h0000;
      cnt_q         <= '0;
      data_o_q      <= '0;
      den_q         <= 1'b0;
      dwe_q         <= 1'b0;
      daddr_q       <= 7'h00;
      di_q          <= 16'h0000;
    end else begin
      state_q       <= state_d;
      owner_man_q   <= owner_man_d;
      man_wr_q      <= man_wr_d;
      man_pending_q <= man_pending_d;
      scan_en_q     <= scan_en_d;
      timeout_q     <= timeout_d;
      slot_q        <= slot_d;
      cache_q       <= cache_d;
      maddr_q       <= maddr_d;
      mdata_q       <= mdata_d;
      rdata_q       <= rdata_d;
      cnt_q         <= cnt_d;
      data_o_q      <= data_o_d;
      den_q         <= den_d;
      dwe_q         <= dwe_d;
      daddr_q       <= daddr_d;
      di_q          <= di_d;
    end
  end

  assign data_o      = data_o_q;
  assign drp_den_o   = den_q;
  assign drp_dwe_o   = dwe_q;
  assign drp_daddr_o = daddr_q;
  assign drp_di_o    = di_q;

endmodule

// File: tb/tb_xadc_drp_scheduler.sv
// Bench for xadc_drp_scheduler: behavioural DRP model, den monitor log, and a
// bus-read scoreboard fed by a vector table and hand-written sequences.
module tb_xadc_drp_scheduler;

  localparam logic [15:0] B = 16'h0040;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic [15:0] address_i = 16'hFFFF;
  logic [7:0]  data_i = 8'h00;
  logic [7:0]  data_o;
  logic        rd_wr_i = 1'b0;
  logic [6:0]  drp_daddr_o;
  logic        drp_den_o;
  logic        drp_dwe_o;
  logic [15:0] drp_di_o;
  logic [15:0] drp_do_i;
  logic        drp_drdy_i;
  logic        drp_busy_i = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  xadc_drp_scheduler #(
    .BaseAddress  (64),
    .address_width(16),
    .data_width   (8),
    .TimeoutCycles(255)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .address_i  (address_i),
    .data_i     (data_i),
    .data_o     (data_o),
    .rd_wr_i    (rd_wr_i),
    .drp_daddr_o(drp_daddr_o),
    .drp_den_o  (drp_den_o),
    .drp_dwe_o  (drp_dwe_o),
    .drp_di_o   (drp_di_o),
    .drp_do_i   (drp_do_i),
    .drp_drdy_i (drp_drdy_i),
    .drp_busy_i (drp_busy_i)
  );

  // DRP model: answers two cycles after sampling den, drives do only with drdy.
  logic [15:0] mem [128];
  int          mcnt;
  logic [6:0]  m_addr;
  logic        m_wr;
  logic        withhold = 1'b0;

  always @(posedge clk) begin
    if (reset_i) begin
      mcnt       <= 0;
      drp_drdy_i <= 1'b0;
      drp_do_i   <= 16'h0000;
    end else begin
      drp_drdy_i <= 1'b0;
      drp_do_i   <= 16'h0000;
      if (drp_den_o) begin
        if (drp_dwe_o) mem[drp_daddr_o] <= drp_di_o;
        if (!withhold) begin
          mcnt   <= 2;
          m_addr <= drp_daddr_o;
          m_wr   <= drp_dwe_o;
        end
      end else if (mcnt > 0) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1) begin
          drp_drdy_i <= 1'b1;
          drp_do_i   <= m_wr ? 16'h0000 : mem[m_addr];
        end
      end
    end
  end

  typedef struct {
    logic [6:0]  addr;
    logic        dwe;
    logic [15:0] di;
    int          cyc;
  } den_t;
  den_t den_log[$];

  always @(posedge clk) begin
    den_t t;
    #2;
    if (drp_den_o === 1'b1) begin
      t.addr = drp_daddr_o;
      t.dwe  = drp_dwe_o;
      t.di   = drp_di_o;
      t.cyc  = cyc;
      den_log.push_back(t);
    end
  end

  typedef struct {
    logic [7:0] exp;
    string      name;
  } rd_t;
  rd_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  always @(posedge clk) begin
    rd_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.name, {24'h0, data_o}, {24'h0, e.exp});
    end
  end

  task automatic drive(input logic [15:0] a, input logic wr, input logic [7:0] d,
                       input logic [7:0] e, input string n, input bit do_chk);
    rd_t r;
    @(negedge clk);
    address_i = a;
    rd_wr_i   = wr;
    data_i    = d;
    if (do_chk) begin
      r.exp = e;
      r.name = n;
      exp_q.push_back(r);
    end
  endtask

  task automatic rd_chk(input logic [15:0] a, input logic [7:0] e, input string n);
    drive(a, 1'b0, 8'h00, e, n, 1'b1);
  endtask

  task automatic wr_reg(input logic [15:0] a, input logic [7:0] d);
    drive(a, 1'b1, d, 8'h00, "", 1'b0);
  endtask

  task automatic idle();
    @(negedge clk);
    rd_wr_i   = 1'b0;
    address_i = 16'hFFFF;
    data_i    = 8'h00;
  endtask

  task automatic poll_status(output logic [7:0] v, output int c);
    drive(B + 16'd4, 1'b0, 8'h00, 8'h00, "", 1'b0);
    @(posedge clk);
    #1;
    v = data_o;
    c = cyc;
  endtask

  task automatic wait_den(input int n, input int budget, input string name, output bit ok);
    ok = 1'b1;
    for (int i = 0; i < budget && den_log.size() < n; i++) @(negedge clk);
    if (den_log.size() < n) begin
      checks++;
      failures++;
      $display("FAIL %s: got %0d den pulses, required %0d", name, den_log.size(), n);
      ok = 1'b0;
    end
  endtask

  function automatic logic [6:0] next_scan(input logic [6:0] a);
    case (a)
      7'h00:   return 7'h01;
      7'h01:   return 7'h02;
      7'h02:   return 7'h06;
      default: return 7'h00;
    endcase
  endfunction

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic [7:0]  data;
    logic [7:0]  exp;
    string       name;
  } vec_t;
  vec_t vecs[22];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    logic [7:0]  v;
    int          c;
    int          n;
    logic [6:0]  x;
    logic [6:0]  seq_exp [5];
    int          t0;

    for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
    mem[7'h00] = 16'h9B20;
    mem[7'h01] = 16'h5511;
    mem[7'h02] = 16'h6622;
    mem[7'h06] = 16'h7733;
    mem[7'h41] = 16'h1234;
    seq_exp[0] = 7'h00; seq_exp[1] = 7'h01; seq_exp[2] = 7'h02;
    seq_exp[3] = 7'h06; seq_exp[4] = 7'h00;

    // read or write, then data_o after the edge (writes must leave it unchanged)
    vecs[0]  = '{B + 16'd0, 1'b0, 8'h00, 8'h9B, "tbl_rd_temp"};
    vecs[1]  = '{B + 16'd5, 1'b1, 8'hC5, 8'h9B, "tbl_wr_hold"};
    vecs[2]  = '{B + 16'd5, 1'b0, 8'h00, 8'h45, "tbl_rd_maddr7"};
    vecs[3]  = '{B + 16'd6, 1'b1, 8'h3C, 8'h45, "tbl_wr_hold2"};
    vecs[4]  = '{B + 16'd6, 1'b0, 8'h00, 8'h3C, "tbl_rd_mdlo"};
    vecs[5]  = '{B + 16'd7, 1'b1, 8'hA5, 8'h3C, "tbl_wr_hold3"};
    vecs[6]  = '{B + 16'd7, 1'b0, 8'h00, 8'hA5, "tbl_rd_mdhi"};
    vecs[7]  = '{B + 16'd0, 1'b1, 8'hFF, 8'hA5, "tbl_wr_ro"};
    vecs[8]  = '{B + 16'd0, 1'b0, 8'h00, 8'h9B, "tbl_rd_temp_ro"};
    vecs[9]  = '{B + 16'd1, 1'b0, 8'h00, 8'h55, "tbl_rd_vccint"};
    vecs[10] = '{B + 16'd2, 1'b0, 8'h00, 8'h66, "tbl_rd_vccaux"};
    vecs[11] = '{B + 16'd3, 1'b0, 8'h00, 8'h77, "tbl_rd_vccbram"};
    vecs[12] = '{B + 16'd4, 1'b0, 8'h00, 8'h01, "tbl_rd_status"};
    vecs[13] = '{B + 16'd8, 1'b0, 8'h00, 8'h00, "tbl_rd_mcmd"};
    vecs[14] = '{B - 16'd1, 1'b0, 8'h00, 8'h00, "tbl_rd_below"};
    vecs[15] = '{B + 16'd9, 1'b0, 8'h00, 8'h00, "tbl_rd_above"};
    vecs[16] = '{B + 16'd8, 1'b1, 8'h07, 8'h00, "tbl_wr_badcmd"};
    vecs[17] = '{B + 16'd4, 1'b0, 8'h00, 8'h01, "tbl_rd_no_pend"};
    vecs[18] = '{B + 16'd4, 1'b1, 8'h00, 8'h01, "tbl_wr_scan_off"};
    vecs[19] = '{B + 16'd4, 1'b0, 8'h00, 8'h00, "tbl_rd_scan_off"};
    vecs[20] = '{B + 16'd4, 1'b1, 8'h01, 8'h00, "tbl_wr_scan_on"};
    vecs[21] = '{B + 16'd4, 1'b0, 8'h00, 8'h01, "tbl_rd_scan_on"};

    // Reset state
    @(negedge clk);
    reset_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data_o", {24'h0, data_o}, 32'h0);
    chk("rst_den", {31'h0, drp_den_o}, 32'h0);
    chk("rst_dwe", {31'h0, drp_dwe_o}, 32'h0);
    chk("rst_daddr", {25'h0, drp_daddr_o}, 32'h0);
    chk("rst_di", {16'h0, drp_di_o}, 32'h0);
    reset_i = 1'b0;
    den_log.delete();

    // First scan result within 10 cycles, then the den address order
    repeat (8) @(negedge clk);
    rd_chk(B, 8'h9B, "first_temp");
    idle();
    wait_den(5, 120, "scan_den_count", ok);
    if (ok) begin
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("scan_daddr_%0d", i), {25'h0, den_log[i].addr}, {25'h0, seq_exp[i]});
        chk($sformatf("scan_dwe_%0d", i), {31'h0, den_log[i].dwe}, 32'h0);
      end
    end
    repeat (20) @(negedge clk);

    foreach (vecs[i]) drive(vecs[i].addr, vecs[i].wr, vecs[i].data, vecs[i].exp, vecs[i].name, 1'b1);
    idle();

    // Manual read issued while a scan transaction is waiting for drdy
    den_log.delete();
    wait_den(1, 60, "mrd_scan_den", ok);
    wr_reg(B + 16'd5, 8'h41);
    wr_reg(B + 16'd8, 8'h01);
    rd_chk(B + 16'd4, 8'h03, "mrd_pending_set");
    idle();
    wait_den(2, 40, "mrd_den", ok);
    if (ok) begin
      chk("mrd_daddr", {25'h0, den_log[1].addr}, 32'h41);
      chk("mrd_dwe", {31'h0, den_log[1].dwe}, 32'h0);
    end
    n = 0;
    do begin
      poll_status(v, c);
      n++;
    end while (v[1] && n < 50);
    rd_chk(B + 16'd6, 8'h34, "mrd_mdata_lo");
    rd_chk(B + 16'd7, 8'h12, "mrd_mdata_hi");
    rd_chk(B + 16'd4, 8'h01, "mrd_pending_clr");
    idle();

    // Manual write: single den+dwe pulse, caches untouched
    wr_reg(B + 16'd5, 8'h42);
    wr_reg(B + 16'd6, 8'hCD);
    wr_reg(B + 16'd7, 8'hAB);
    den_log.delete();
    wr_reg(B + 16'd8, 8'h02);
    idle();
    repeat (40) @(negedge clk);
    n = 0;
    foreach (den_log[i]) begin
      if (den_log[i].dwe) begin
        n++;
        chk("mwr_daddr", {25'h0, den_log[i].addr}, 32'h42);
        chk("mwr_di", {16'h0, den_log[i].di}, 32'hABCD);
      end
    end
    chk("mwr_dwe_pulses", n, 1);
    chk("mwr_model_mem", {16'h0, mem[7'h42]}, 32'hABCD);
    rd_chk(B + 16'd6, 8'hCD, "mwr_mdata_kept");
    rd_chk(B + 16'd0, 8'h9B, "mwr_cache0");
    rd_chk(B + 16'd1, 8'h55, "mwr_cache1");
    rd_chk(B + 16'd2, 8'h66, "mwr_cache2");
    rd_chk(B + 16'd3, 8'h77, "mwr_cache3");
    rd_chk(B + 16'd4, 8'h01, "mwr_status");
    idle();

    // Timeout on a withheld scan transaction
    withhold = 1'b1;
    den_log.delete();
    wait_den(1, 60, "to_den", ok);
    @(negedge clk);
    withhold = 1'b0;
    if (ok) begin
      x  = den_log[0].addr;
      t0 = den_log[0].cyc;
      n  = 0;
      do begin
        poll_status(v, c);
        n++;
      end while (!v[2] && n < 400);
      chk("to_flag_seen", {31'h0, v[2]}, 32'h1);
      checks++;
      if (c - t0 < 250 || c - t0 > 262) begin
        failures++;
        $display("FAIL to_latency: got %0d cycles, required about 256", c - t0);
      end
      rd_chk(B + 16'd4, 8'h05, "to_status");
      idle();
      wait_den(2, 40, "to_next_den", ok);
      if (ok) chk("to_next_slot", {25'h0, den_log[1].addr}, {25'h0, next_scan(x)});
      wr_reg(B + 16'd4, 8'h05);
      rd_chk(B + 16'd4, 8'h01, "to_cleared");
      idle();
    end

    // Reset pulse while a scan of slot 2 is waiting for drdy
    for (int k = 0; k < 8; k++) begin
      den_log.delete();
      wait_den(1, 60, "rst_wait_den", ok);
      if (!ok || den_log[0].addr == 7'h02) break;
    end
    reset_i = 1'b1;
    @(negedge clk);
    chk("midrst_den", {31'h0, drp_den_o}, 32'h0);
    chk("midrst_daddr", {25'h0, drp_daddr_o}, 32'h0);
    chk("midrst_di", {16'h0, drp_di_o}, 32'h0);
    reset_i = 1'b0;
    den_log.delete();
    for (int i = 0; i < 8; i++)
      rd_chk(B + 16'(i), (i == 4) ? 8'h01 : 8'h00, $sformatf("midrst_reg%0d", i));
    idle();
    wait_den(2, 60, "midrst_dens", ok);
    if (ok) begin
      chk("midrst_slot0", {25'h0, den_log[0].addr}, 32'h00);
      chk("midrst_slot1", {25'h0, den_log[1].addr}, 32'h01);
    end

    // busy holds off the scheduler; den follows two cycles after release
    drp_busy_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    den_log.delete();
    repeat (50) @(negedge clk);
    chk("busy_no_den", den_log.size(), 0);
    drp_busy_i = 1'b0;
    n = 0;
    while (den_log.size() == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("busy_release_latency", n, 2);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
